// File: rtl/pbit_pkg.sv
// Shared constants, FSM state type and activation clamp for the p-bit sampler.
package pbit_pkg;

  // Width of the random word delivered by the LFSR generator.
  localparam int unsigned RND_W = 8;

  // Activation is a 9-bit unsigned value in 0..ACT_MAX.
  localparam int unsigned ACT_W   = 9;
  localparam int          ACT_MID = 128;
  localparam int          ACT_MAX = 256;

  // Sample-counting FSM states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Saturate a signed biased current into the 0..ACT_MAX activation range.
  function automatic logic [ACT_W-1:0] clamp_act(input logic signed [31:0] x);
    logic [ACT_W-1:0] res;
    if (x < 0) begin
      res = '0;
    end else if (x > ACT_MAX) begin
      res = ACT_W'(ACT_MAX);
    end else begin
      res = x[ACT_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/pbit_activation.sv
// Combinational activation: scale the signed input current by the inverse
// temperature (a left shift), centre it on ACT_MID and saturate to 0..ACT_MAX.
module pbit_activation
  import pbit_pkg::*;
#(
  parameter int unsigned IW         = 8,
  parameter int unsigned BETA_SHIFT = 1
) (
  input  logic signed [IW-1:0]    cur_i,
  output logic        [ACT_W-1:0] act_o
);

  // Two guard bits: one for the shift headroom sign, one for the +ACT_MID bias.
  localparam int unsigned SW = IW + BETA_SHIFT + 2;

  logic signed [SW-1:0] cur_ext;
  logic signed [SW-1:0] cur_shifted;
  logic signed [SW-1:0] cur_biased;
  logic signed [31:0]   cur_biased_ext;

  // Sign-extend, scale, bias and clamp the input current.
  always_comb begin
    cur_ext        = {{(SW - IW){cur_i[IW-1]}}, cur_i};
    cur_shifted    = cur_ext <<< BETA_SHIFT;
    cur_biased     = cur_shifted + SW'(ACT_MID);
    cur_biased_ext = {{(32 - SW){cur_biased[SW-1]}}, cur_biased};
    act_o          = clamp_act(cur_biased_ext);
  end

endmodule

// File: rtl/pbit_sampler.sv
// Stochastic p-bit: a two-stage pipeline turns a signed input current and a
// random word into a binary state m, and a small FSM counts how many updates
// came out as 1 over a requested number of samples.
module pbit_sampler
  import pbit_pkg::*;
#(
  parameter int unsigned IW         = 8,
  parameter int unsigned BETA_SHIFT = 1,
  parameter int unsigned NS_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [RND_W-1:0]     rnd,
  input  logic                 en,
  input  logic signed [IW-1:0] i_in,
  input  logic                 start,
  input  logic [NS_W-1:0]      n_samples,
  output logic                 m,
  output logic                 m_valid,
  output logic                 busy,
  output logic                 done,
  output logic [NS_W-1:0]      ones_cnt
);

  // ---------------------------------------------------------------------------
  // Activation (stage 1 input)
  // ---------------------------------------------------------------------------
  logic [ACT_W-1:0] act;

  pbit_activation #(
    .IW         (IW),
    .BETA_SHIFT (BETA_SHIFT)
  ) u_activation (
    .cur_i (i_in),
    .act_o (act)
  );

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  logic [ACT_W-1:0] act_q, act_d;
  logic             v1_q, v1_d;
  logic             m_q, m_d;
  logic             m_valid_q, m_valid_d;

  // Stage 1 captures the activation; stage 2 compares it with the live random word.
  always_comb begin
    act_d     = act_q;
    v1_d      = en;
    m_d       = m_q;
    m_valid_d = v1_q;
    if (en) begin
      act_d = act;
    end
    if (v1_q) begin
      // act = ACT_MAX always wins and act = 0 never does, for any 8-bit rnd.
      m_d = ({1'b0, rnd} < act_q);
    end
  end

  // Pipeline state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_q     <= '0;
      v1_q      <= 1'b0;
      m_q       <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      act_q     <= act_d;
      v1_q      <= v1_d;
      m_q       <= m_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign m       = m_q;
  assign m_valid = m_valid_q;

  // ---------------------------------------------------------------------------
  // Sample-counting FSM
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [NS_W-1:0] rem_q, rem_d;
  logic [NS_W-1:0] ones_q, ones_d;
  logic            busy_d, done_d;

  // Next-state logic and Moore outputs; only m_valid pulses seen in StRun count.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    ones_d  = ones_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          ones_d = '0;
          if (n_samples != '0) begin
            rem_d   = n_samples;
            state_d = StRun;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        busy_d = 1'b1;
        if (m_valid_q) begin
          ones_d = ones_q + NS_W'(m_q);
          rem_d  = rem_q - NS_W'(1);
          if (rem_q == NS_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // FSM state, remaining-sample counter and ones accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      rem_q   <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ones_q  <= ones_d;
    end
  end

  assign busy     = busy_d;
  assign done     = done_d;
  assign ones_cnt = ones_q;

endmodule

// File: tb/tb_pbit_sampler.sv
// Directed bench for pbit_sampler; rnd comes from a bench-side maximal 8-bit LFSR.
module tb_pbit_sampler;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        rnd;
  logic              en;
  logic signed [7:0] i_in;
  logic              start;
  logic [7:0]        n_samples;
  logic              m;
  logic              m_valid;
  logic              busy;
  logic              done;
  logic [7:0]        ones_cnt;

  int errors = 0;
  int checks = 0;

  // Bookkeeping sampled after every edge.
  int run_mv;
  int run_m1;
  int done_cnt;
  int busy_cnt;
  int mv_at_done;
  bit ok;

  pbit_sampler #(
    .IW         (8),
    .BETA_SHIFT (1),
    .NS_W       (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rnd       (rnd),
    .en        (en),
    .i_in      (i_in),
    .start     (start),
    .n_samples (n_samples),
    .m         (m),
    .m_valid   (m_valid),
    .busy      (busy),
    .done      (done),
    .ones_cnt  (ones_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // x^8+x^6+x^5+x^4+1, Galois form: visits every nonzero value once per 255 steps.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    run_mv     = 0;
    run_m1     = 0;
    done_cnt   = 0;
    busy_cnt   = 0;
    mv_at_done = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rnd = lfsr_next(rnd);
    if (busy === 1'b1 && m_valid === 1'b1) begin
      run_mv++;
      if (m === 1'b1) run_m1++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      mv_at_done = run_mv;
    end
    if (busy === 1'b1) busy_cnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_run(input logic [7:0] n);
    start     = 1'b1;
    n_samples = n;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    rnd       = 8'h6a;
    en        = 1'b0;
    i_in      = '0;
    start     = 1'b0;
    n_samples = '0;
    clear_counts();
    ticks(2);

    // Reset state.
    check("rst_m", m, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ones", ones_cnt, 0);

    // Saturate high: act = 100*2+128 clamps to 256, m always 1.
    reset = 1'b0;
    i_in  = 8'sd100;
    en    = 1'b1;
    ticks(3);
    clear_counts();
    start_run(8'd200);
    check("hi_busy", busy, 1);
    wait_done(400, ok);
    check("hi_done_seen", ok, 1);
    check("hi_mv", run_mv, 200);
    check("hi_m1", run_m1, 200);
    check("hi_ones", ones_cnt, 200);
    check("hi_m", m, 1);
    tick();
    check("hi_done_1cyc", done, 0);
    check("hi_ones_hold", ones_cnt, 200);

    // Saturate low: act = -200+128 clamps to 0, m always 0.
    i_in = -8'sd100;
    ticks(3);
    clear_counts();
    start_run(8'd200);
    wait_done(400, ok);
    check("lo_done_seen", ok, 1);
    check("lo_mv", run_mv, 200);
    check("lo_m1", run_m1, 0);
    check("lo_ones", ones_cnt, 0);
    tick();
    check("lo_done_1cyc", done, 0);
    check("lo_done_cnt", done_cnt, 1);

    // Zero bias over one full LFSR period: rnd 1..127 give m=1.
    i_in = 8'sd0;
    ticks(3);
    clear_counts();
    start_run(8'd255);
    wait_done(600, ok);
    check("fp_done_seen", ok, 1);
    check("fp_mv", run_mv, 255);
    check("fp_ones", ones_cnt, 127);

    // Latency: single en pulse gives exactly one m_valid, two edges later.
    en = 1'b0;
    ticks(3);
    check("lat_idle_mv", m_valid, 0);
    i_in = 8'sd127;
    en   = 1'b1;
    tick();
    en   = 1'b0;
    i_in = -8'sd128;
    check("lat_t_mv", m_valid, 0);
    tick();
    check("lat_t1_mv", m_valid, 1);
    check("lat_t1_m", m, 1);
    tick();
    check("lat_t2_mv", m_valid, 0);
    tick();
    check("lat_t3_mv", m_valid, 0);
    check("lat_t3_m_hold", m, 1);

    // n_samples = 0: done next cycle, never busy, count cleared.
    clear_counts();
    start_run(8'd0);
    check("z_done", done, 1);
    check("z_busy", busy, 0);
    check("z_ones", ones_cnt, 0);
    tick();
    check("z_done_1cyc", done, 0);
    check("z_busy_cnt", busy_cnt, 0);

    // 10-sample run with 3-cycle en gaps, alternating m, and a start mid-run.
    ticks(2);
    clear_counts();
    start_run(8'd10);
    for (int k = 0; k < 10; k++) begin
      i_in = (k % 2 == 1) ? 8'sd127 : -8'sd128;
      en   = 1'b1;
      if (k == 4) begin
        start     = 1'b1;
        n_samples = 8'd3;
      end
      tick();
      en    = 1'b0;
      start = 1'b0;
      ticks(3);
    end
    ticks(3);
    check("gap_done_cnt", done_cnt, 1);
    check("gap_mv_at_done", mv_at_done, 10);
    check("gap_mv", run_mv, 10);
    check("gap_ones", ones_cnt, 5);

    // Reset mid-run after 50 of 100 samples.
    i_in = 8'sd127;
    en   = 1'b1;
    ticks(2);
    clear_counts();
    start_run(8'd100);
    for (int i = 0; i < 200 && run_mv < 50; i++) tick();
    check("mid_mv", run_mv, 50);
    check("mid_ones", ones_cnt, 49);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_m", m, 0);
    check("mr_m_valid", m_valid, 0);
    check("mr_busy", busy, 0);
    check("mr_done", done, 0);
    check("mr_ones", ones_cnt, 0);
    clear_counts();
    ticks(4);
    check("mr_no_done", done_cnt, 0);
    check("mr_idle", busy_cnt, 0);
    clear_counts();
    start_run(8'd20);
    wait_done(100, ok);
    check("mr2_done_seen", ok, 1);
    check("mr2_mv", run_mv, 20);
    check("mr2_ones", ones_cnt, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
